// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: shares one data-memory bus between the LSU (port 0) and a
// secondary master (port 1). Round-robin arbitration, request locking until
// grant, and an in-order outstanding-ID FIFO for routing responses.
// Build option: define DATA_BUS_ARB_FIXED_PRIO_EN for fixed priority
// (port 0 always wins on contention); otherwise round-robin.
module data_bus_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req_i,
    input  logic [ADDR_W-1:0]     p0_add_i,
    input  logic                  p0_we_i,
    input  logic [DATA_W/8-1:0]   p0_be_i,
    input  logic [DATA_W-1:0]     p0_wdata_i,
    output logic                  p0_gnt_o,
    output logic                  p0_rvalid_o,
    output logic [DATA_W-1:0]     p0_rdata_o,
    input  logic                  p1_req_i,
    input  logic [ADDR_W-1:0]     p1_add_i,
    input  logic                  p1_we_i,
    input  logic [DATA_W/8-1:0]   p1_be_i,
    input  logic [DATA_W-1:0]     p1_wdata_i,
    output logic                  p1_gnt_o,
    output logic                  p1_rvalid_o,
    output logic [DATA_W-1:0]     p1_rdata_o,
    output logic                  data_req_o,
    output logic [ADDR_W-1:0]     data_add_o,
    output logic                  data_we_o,
    output logic [DATA_W/8-1:0]   data_be_o,
    output logic [DATA_W-1:0]     data_wdata_o,
    input  logic                  data_gnt_in,
    input  logic                  data_rvalid,
    input  logic [DATA_W-1:0]     data_rdata_in,
    output logic                  spurious_o
);

    localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTST);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTST - 1);

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic                 sel_q, sel_d;
`ifndef DATA_BUS_ARB_FIXED_PRIO_EN
    logic                 prio_q;
`endif

    logic [MAX_OUTST-1:0] id_q;
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 empty, full, accept, pop, head;

    assign empty  = (count_q == '0);
    assign full   = (count_q == FULL_CNT);
    assign head   = id_q[rd_ptr_q];
    assign accept = data_req_o && data_gnt_in;

    // Read data is shared; only the rvalid qualifies which port owns it.
    assign p0_rdata_o = data_rdata_in;
    assign p1_rdata_o = data_rdata_in;

    // Response routing: pop the head ID, flag responses with nothing outstanding.
    always_comb begin
        pop         = 1'b0;
        spurious_o  = 1'b0;
        p0_rvalid_o = 1'b0;
        p1_rvalid_o = 1'b0;
        if (!rst && data_rvalid) begin
            if (empty) begin
                spurious_o = 1'b1;
            end else begin
                pop         = 1'b1;
                p0_rvalid_o = !head;
                p1_rvalid_o = head;
            end
        end
    end

    // Next state, port selection, bus request and grant forwarding.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        data_req_o = 1'b0;
        case (state_q)
            ST_ARB: begin
                if (p0_req_i && p1_req_i) begin
`ifdef DATA_BUS_ARB_FIXED_PRIO_EN
                    sel_d = 1'b0;
`else
                    sel_d = prio_q;
`endif
                end else begin
                    sel_d = p1_req_i;
                end
                // A full FIFO blocks new requests even if a pop lands this cycle.
                data_req_o = (p0_req_i || p1_req_i) && !full;
                if (data_req_o && !data_gnt_in) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                data_req_o = 1'b1;
                if (data_gnt_in) begin
                    state_d = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
        if (rst) begin
            data_req_o = 1'b0;
            state_d    = ST_ARB;
        end
        data_add_o   = sel_d ? p1_add_i   : p0_add_i;
        data_we_o    = sel_d ? p1_we_i    : p0_we_i;
        data_be_o    = sel_d ? p1_be_i    : p0_be_i;
        data_wdata_o = sel_d ? p1_wdata_i : p0_wdata_i;
        p0_gnt_o     = data_gnt_in && data_req_o && !sel_d;
        p1_gnt_o     = data_gnt_in && data_req_o && sel_d;
    end

    // FSM state, held selection and round-robin priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ARB;
            sel_q   <= 1'b0;
`ifndef DATA_BUS_ARB_FIXED_PRIO_EN
            prio_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
`ifndef DATA_BUS_ARB_FIXED_PRIO_EN
            if (accept) begin
                prio_q <= !sel_d;
            end
`endif
        end
    end

    // Outstanding-ID FIFO: push the granted port on acceptance, pop on rvalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                id_q[wr_ptr_q] <= sel_d;
                wr_ptr_q       <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed self-checking bench for data_bus_arbiter (MAX_OUTST = 2).
module tb_data_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req_i, p1_req_i;
    logic [31:0] p0_add_i, p1_add_i;
    logic        p0_we_i, p1_we_i;
    logic [3:0]  p0_be_i, p1_be_i;
    logic [31:0] p0_wdata_i, p1_wdata_i;
    logic        p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o;
    logic [31:0] p0_rdata_o, p1_rdata_o;
    logic        data_req_o, data_we_o;
    logic [31:0] data_add_o, data_wdata_o;
    logic [3:0]  data_be_o;
    logic        data_gnt_in, data_rvalid;
    logic [31:0] data_rdata_in;
    logic        spurious_o;

    int checks = 0;
    int errors = 0;

    data_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(2)) dut (
        .clk(clk), .rst(rst),
        .p0_req_i(p0_req_i), .p0_add_i(p0_add_i), .p0_we_i(p0_we_i), .p0_be_i(p0_be_i),
        .p0_wdata_i(p0_wdata_i), .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
        .p1_req_i(p1_req_i), .p1_add_i(p1_add_i), .p1_we_i(p1_we_i), .p1_be_i(p1_be_i),
        .p1_wdata_i(p1_wdata_i), .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
        .data_req_o(data_req_o), .data_add_o(data_add_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_wdata_o(data_wdata_o), .data_gnt_in(data_gnt_in), .data_rvalid(data_rvalid),
        .data_rdata_in(data_rdata_in), .spurious_o(spurious_o)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus on the falling edge, then settle before checks.
    task automatic drive(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1,
                         input logic gnt, input logic rv, input logic [31:0] rdata);
        @(negedge clk);
        p0_req_i = r0; p0_add_i = a0;
        p1_req_i = r1; p1_add_i = a1;
        data_gnt_in = gnt; data_rvalid = rv; data_rdata_in = rdata;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        p0_req_i = 1'b0; p1_req_i = 1'b0; data_gnt_in = 1'b0; data_rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        p0_req_i = 1'b1; p0_add_i = 32'h100; data_gnt_in = 1'b1; data_rvalid = 1'b1;
        #1;
        checks++; if (data_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", data_req_o); end
        checks++; if (p0_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b expected 0", p0_gnt_o); end
        checks++; if ({p0_rvalid_o, p1_rvalid_o, spurious_o} !== 3'b000) begin errors++;
            $display("FAIL reset_rvalid: got %b expected 000", {p0_rvalid_o, p1_rvalid_o, spurious_o}); end
        do_reset();
    endtask

    task automatic test_basic();
        drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (data_add_o !== 32'h100) begin errors++; $display("FAIL basic_add: got %h expected 00000100", data_add_o); end
        checks++; if ({data_req_o, p0_gnt_o, p1_gnt_o} !== 3'b110) begin errors++;
            $display("FAIL basic_gnt: got %b expected 110", {data_req_o, p0_gnt_o, p1_gnt_o}); end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        checks++; if ({p0_rvalid_o, p1_rvalid_o} !== 2'b10) begin errors++;
            $display("FAIL basic_rvalid: got %b expected 10", {p0_rvalid_o, p1_rvalid_o}); end
        checks++; if (p0_rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rdata: got %h expected deadbeef", p0_rdata_o); end
        do_reset();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_gnt;
        logic       prev;
        prev = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h10, 1'b1, 32'h20, 1'b1, (i > 0), 32'h0);
`ifdef DATA_BUS_ARB_FIXED_PRIO_EN
            exp_gnt = 2'b10;
`else
            exp_gnt = (i % 2 == 0) ? 2'b10 : 2'b01;
`endif
            checks++; if ({p0_gnt_o, p1_gnt_o} !== exp_gnt) begin errors++;
                $display("FAIL rr_gnt[%0d]: got %b expected %b", i, {p0_gnt_o, p1_gnt_o}, exp_gnt); end
            if (i > 0) begin
                checks++; if ({p0_rvalid_o, p1_rvalid_o} !== {!prev, prev}) begin errors++;
                    $display("FAIL rr_rvalid[%0d]: got %b expected %b", i, {p0_rvalid_o, p1_rvalid_o}, {!prev, prev}); end
            end
            prev = exp_gnt[0];
        end
        do_reset();
    endtask

    task automatic test_lock();
        // Grant p0 once so round-robin would favour p1 on contention.
        drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 32'h200, 1'b0, 32'h300, 1'b0, 1'b1, 32'h0);
        checks++; if ({data_req_o, p0_gnt_o, data_add_o} !== {2'b10, 32'h200}) begin errors++;
            $display("FAIL lock_c1: got req=%b gnt=%b add=%h expected 1 0 200", data_req_o, p0_gnt_o, data_add_o); end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
            checks++; if ({data_req_o, data_add_o} !== {1'b1, 32'h200}) begin errors++;
                $display("FAIL lock_hold[%0d]: got req=%b add=%h expected 1 200", i, data_req_o, data_add_o); end
        end
        drive(1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 1'b0, 32'h0);
        checks++; if ({p0_gnt_o, p1_gnt_o, data_add_o} !== {2'b10, 32'h200}) begin errors++;
            $display("FAIL lock_gnt: got %b%b add=%h expected 10 200", p0_gnt_o, p1_gnt_o, data_add_o); end
        drive(1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 1'b0, 32'h0);
        checks++; if ({p0_gnt_o, p1_gnt_o, data_add_o} !== {2'b01, 32'h300}) begin errors++;
            $display("FAIL lock_next: got %b%b add=%h expected 01 300", p0_gnt_o, p1_gnt_o, data_add_o); end
        checks++; if ({data_we_o, data_be_o, data_wdata_o} !== {1'b1, 4'hC, 32'hCAFEF00D}) begin errors++;
            $display("FAIL lock_mux: got we=%b be=%h wd=%h expected 1 c cafef00d", data_we_o, data_be_o, data_wdata_o); end
        do_reset();
    endtask

    task automatic test_full();
        drive(1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h0);
        checks++; if (p1_gnt_o !== 1'b1) begin errors++; $display("FAIL full_second: got %b expected 1", p1_gnt_o); end
        drive(1'b1, 32'h30, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if ({data_req_o, p0_gnt_o} !== 2'b00) begin errors++;
            $display("FAIL full_block: got %b expected 00", {data_req_o, p0_gnt_o}); end
        drive(1'b1, 32'h30, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        checks++; if ({data_req_o, p0_gnt_o, p0_rvalid_o} !== 3'b001) begin errors++;
            $display("FAIL full_pop_same: got %b expected 001", {data_req_o, p0_gnt_o, p0_rvalid_o}); end
        drive(1'b1, 32'h30, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if ({data_req_o, p0_gnt_o} !== 2'b11) begin errors++;
            $display("FAIL full_resume: got %b expected 11", {data_req_o, p0_gnt_o}); end
        do_reset();
    endtask

    task automatic test_ordering();
        drive(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 32'h50, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (p0_gnt_o !== 1'b1) begin errors++; $display("FAIL ord_accept: got %b expected 1", p0_gnt_o); end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1111);
        checks++; if ({p0_rvalid_o, p1_rvalid_o, p1_rdata_o} !== {2'b01, 32'h1111}) begin errors++;
            $display("FAIL ord_first: got %b%b %h expected 01 1111", p0_rvalid_o, p1_rvalid_o, p1_rdata_o); end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2222);
        checks++; if ({p0_rvalid_o, p1_rvalid_o} !== 2'b10) begin errors++;
            $display("FAIL ord_second: got %b expected 10", {p0_rvalid_o, p1_rvalid_o}); end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        checks++; if ({p0_rvalid_o, p1_rvalid_o, spurious_o} !== 3'b001) begin errors++;
            $display("FAIL ord_drained: got %b expected 001", {p0_rvalid_o, p1_rvalid_o, spurious_o}); end
        do_reset();
    endtask

    task automatic test_spurious();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        checks++; if ({p0_rvalid_o, p1_rvalid_o, spurious_o} !== 3'b001) begin errors++;
            $display("FAIL spur_pulse: got %b expected 001", {p0_rvalid_o, p1_rvalid_o, spurious_o}); end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (spurious_o !== 1'b0) begin errors++; $display("FAIL spur_clear: got %b expected 0", spurious_o); end
        drive(1'b1, 32'h60, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        checks++; if ({p0_rvalid_o, spurious_o} !== 2'b10) begin errors++;
            $display("FAIL spur_no_underflow: got %b expected 10", {p0_rvalid_o, spurious_o}); end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        checks++; if ({p0_rvalid_o, spurious_o} !== 2'b01) begin errors++;
            $display("FAIL spur_empty_again: got %b expected 01", {p0_rvalid_o, spurious_o}); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h70, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 32'h74, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b1; p0_req_i = 1'b1; data_gnt_in = 1'b1; data_rvalid = 1'b1;
        #1;
        checks++; if ({data_req_o, p0_gnt_o, p0_rvalid_o, spurious_o} !== 4'b0000) begin errors++;
            $display("FAIL rstmid_forced: got %b expected 0000", {data_req_o, p0_gnt_o, p0_rvalid_o, spurious_o}); end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        rst = 1'b0;
        #1;
        checks++; if ({p0_rvalid_o, p1_rvalid_o, spurious_o} !== 3'b001) begin errors++;
            $display("FAIL rstmid_empty: got %b expected 001", {p0_rvalid_o, p1_rvalid_o, spurious_o}); end
        drive(1'b1, 32'h80, 1'b1, 32'h90, 1'b1, 1'b0, 32'h0);
        checks++; if ({data_req_o, p0_gnt_o, p1_gnt_o} !== 3'b110) begin errors++;
            $display("FAIL rstmid_prio: got %b expected 110", {data_req_o, p0_gnt_o, p1_gnt_o}); end
        do_reset();
    endtask

    initial begin
        rst = 1'b1;
        p0_req_i = 1'b0; p0_add_i = '0; p0_we_i = 1'b0; p0_be_i = 4'hF; p0_wdata_i = 32'h0;
        p1_req_i = 1'b0; p1_add_i = '0; p1_we_i = 1'b1; p1_be_i = 4'hC; p1_wdata_i = 32'hCAFEF00D;
        data_gnt_in = 1'b0; data_rvalid = 1'b0; data_rdata_in = '0;
        test_reset();
        test_basic();
        test_round_robin();
        test_lock();
        test_full();
        test_ordering();
        test_spurious();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
